wrf_rr_arbiter: RTL and testbench

- Parametrised N:1 WR fabric (pipelined Wishbone) frame arbiter for the switch datapath.
- Merges NUM_PORTS fabric sources into one fabric source toward the switch core.
- Round-robin per frame: a port holds the grant for its whole cyc burst, and words of different frames never interleave.
- Tracks outstanding acks so the output cycle closes cleanly.

---
 rtl/wrf_rr_arbiter.sv | 166 ++++++++++++++++
 tb/tb_wrf_rr_arbiter.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/wrf_rr_arbiter.sv
// wrf_rr_arbiter: N:1 pipelined WR fabric arbiter, round-robin per frame, outstanding-ack tracking.
// Optional idle watchdog is built when WRF_ARB_TIMEOUT_EN is defined.
module wrf_rr_arbiter #(
  parameter int NUM_PORTS       = 8,
  parameter int DATA_WIDTH      = 16,
  parameter int MAX_OUTSTANDING = 4,
  parameter int TIMEOUT_CYCLES  = 1024
) (
  input  logic                                  clk_sys,
  input  logic                                  rst,
  input  logic [NUM_PORTS-1:0]                  snk_cyc_i,
  input  logic [NUM_PORTS-1:0]                  snk_stb_i,
  input  logic [NUM_PORTS-1:0]                  snk_we_i,
  input  logic [2*NUM_PORTS-1:0]                snk_adr_i,
  input  logic [DATA_WIDTH*NUM_PORTS-1:0]       snk_dat_i,
  input  logic [(DATA_WIDTH/8)*NUM_PORTS-1:0]   snk_sel_i,
  output logic [NUM_PORTS-1:0]                  snk_ack_o,
  output logic [NUM_PORTS-1:0]                  snk_err_o,
  output logic [NUM_PORTS-1:0]                  snk_rty_o,
  output logic [NUM_PORTS-1:0]                  snk_stall_o,
  output logic                                  src_cyc_o,
  output logic                                  src_stb_o,
  output logic                                  src_we_o,
  output logic [1:0]                            src_adr_o,
  output logic [DATA_WIDTH-1:0]                 src_dat_o,
  output logic [DATA_WIDTH/8-1:0]               src_sel_o,
  input  logic                                  src_ack_i,
  input  logic                                  src_err_i,
  input  logic                                  src_rty_i,
  input  logic                                  src_stall_i,
  output logic [NUM_PORTS-1:0]                  grant_o,
  output logic                                  busy_o
);

  localparam int PW = $clog2(NUM_PORTS);
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int SW = DATA_WIDTH / 8;
  localparam logic [OW-1:0] MAX_OUT = OW'(MAX_OUTSTANDING);

  if (NUM_PORTS < 2 || NUM_PORTS > 16 || (DATA_WIDTH % 8) != 0 ||
      MAX_OUTSTANDING < 1 || MAX_OUTSTANDING > 15 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("wrf_rr_arbiter: parameter out of range");
  end

  typedef enum logic [1:0] {IDLE, GRANT, DRAIN} state_t;

  state_t        state_reg, state_next;
  logic [PW-1:0] gnt_reg, gnt_next;
  logic [PW-1:0] rr_ptr_reg, rr_ptr_next;
  logic [OW-1:0] outst_reg, outst_next, outst_step;
  logic [PW-1:0] pick;
  logic          found;
  logic          busy, in_grant, g_cyc, g_stb, outst_full;
  logic          accept, rsp, rsp_valid, timeout;

  assign busy       = (state_reg != IDLE);
  assign in_grant   = (state_reg == GRANT);
  assign g_cyc      = snk_cyc_i[gnt_reg];
  assign g_stb      = snk_stb_i[gnt_reg];
  assign outst_full = (outst_reg == MAX_OUT);

  assign src_cyc_o = busy;
  assign busy_o    = busy;
  assign src_stb_o = in_grant & g_cyc & g_stb & ~outst_full;
  assign src_we_o  = in_grant & snk_we_i[gnt_reg];
  assign src_adr_o = in_grant ? snk_adr_i[gnt_reg*2 +: 2] : 2'b00;
  assign src_dat_o = in_grant ? snk_dat_i[gnt_reg*DATA_WIDTH +: DATA_WIDTH] : '0;
  assign src_sel_o = in_grant ? snk_sel_i[gnt_reg*SW +: SW] : '0;

  assign accept    = src_stb_o & ~src_stall_i;
  assign rsp       = busy & (src_ack_i | src_err_i | src_rty_i);
  // A response with nothing outstanding is stray and must not underflow the counter.
  assign rsp_valid = rsp & (outst_reg != '0);

  // Round-robin search starting just after the last granted port.
  always_comb begin
    pick  = rr_ptr_reg;
    found = 1'b0;
    for (int k = 1; k <= NUM_PORTS; k++) begin
      if (!found && snk_cyc_i[(int'(rr_ptr_reg) + k) % NUM_PORTS]) begin
        pick  = PW'((int'(rr_ptr_reg) + k) % NUM_PORTS);
        found = 1'b1;
      end
    end
  end

  always_comb begin
    outst_step = outst_reg;
    if (accept && !rsp_valid)
      outst_step = outst_reg + 1'b1;
    else if (!accept && rsp_valid)
      outst_step = outst_reg - 1'b1;
  end

  assign outst_next = timeout ? '0 : outst_step;

  // Frame end and drain exit use the post-update count, so an ack in the same cycle counts.
  always_comb begin
    state_next  = state_reg;
    gnt_next    = gnt_reg;
    rr_ptr_next = rr_ptr_reg;
    case (state_reg)
      IDLE: begin
        if (|snk_cyc_i) begin
          state_next  = GRANT;
          gnt_next    = pick;
          rr_ptr_next = pick;
        end
      end
      GRANT: begin
        if (timeout)
          state_next = IDLE;
        else if (!g_cyc)
          state_next = (outst_step == '0) ? IDLE : DRAIN;
      end
      DRAIN: begin
        if (timeout || outst_step == '0)
          state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      state_reg  <= IDLE;
      gnt_reg    <= '0;
      rr_ptr_reg <= PW'(NUM_PORTS - 1);
      outst_reg  <= '0;
    end else begin
      state_reg  <= state_next;
      gnt_reg    <= gnt_next;
      rr_ptr_reg <= rr_ptr_next;
      outst_reg  <= outst_next;
    end
  end

  for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
    logic sel_g;
    assign sel_g          = busy && (gnt_reg == PW'(gi));
    assign grant_o[gi]    = sel_g;
    assign snk_ack_o[gi]  = sel_g & src_ack_i;
    assign snk_err_o[gi]  = sel_g & (src_err_i | timeout);
    assign snk_rty_o[gi]  = sel_g & src_rty_i;
    assign snk_stall_o[gi] = ~(in_grant & sel_g) | src_stall_i | outst_full;
  end

`ifdef WRF_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] wd_reg;
  logic          quiet;

  assign quiet   = busy & ~accept & ~rsp;
  assign timeout = quiet && (wd_reg == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk_sys) begin
    if (rst || !quiet || timeout)
      wd_reg <= '0;
    else
      wd_reg <= wd_reg + 1'b1;
  end
`else
  assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_wrf_rr_arbiter.sv
// Directed self-checking bench for wrf_rr_arbiter (4 ports, 16-bit data, 4 outstanding).
module tb_wrf_rr_arbiter;
  localparam int NP = 4;
  localparam int DW = 16;
  localparam int SW = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic [NP-1:0]     cyc, stb, we;
  logic [2*NP-1:0]   adr;
  logic [DW*NP-1:0]  dat;
  logic [SW*NP-1:0]  sel;
  logic [NP-1:0]     ack_o, err_o, rty_o, stall_o, grant;
  logic              src_cyc, src_stb, src_we, busy;
  logic [1:0]        src_adr;
  logic [DW-1:0]     src_dat;
  logic [SW-1:0]     src_sel;
  logic              ack, err, rty, stall;

  int errors = 0;
  int checks = 0;
  logic [DW-1:0] rx_q[$];
  int order[4] = '{1, 3, 1, 3};

  wrf_rr_arbiter #(
    .NUM_PORTS(NP), .DATA_WIDTH(DW), .MAX_OUTSTANDING(4), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk_sys(clk), .rst(rst),
    .snk_cyc_i(cyc), .snk_stb_i(stb), .snk_we_i(we), .snk_adr_i(adr),
    .snk_dat_i(dat), .snk_sel_i(sel),
    .snk_ack_o(ack_o), .snk_err_o(err_o), .snk_rty_o(rty_o), .snk_stall_o(stall_o),
    .src_cyc_o(src_cyc), .src_stb_o(src_stb), .src_we_o(src_we), .src_adr_o(src_adr),
    .src_dat_o(src_dat), .src_sel_o(src_sel),
    .src_ack_i(ack), .src_err_i(err), .src_rty_i(rty), .src_stall_i(stall),
    .grant_o(grant), .busy_o(busy)
  );

  // Record every word the downstream side accepts, sampled mid-cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (src_stb && !stall) rx_q.push_back(src_dat);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_dat(input int p, input logic [DW-1:0] v);
    dat[p*DW +: DW] = v;
  endtask

  task automatic check_rx(input string tag, input logic [DW-1:0] base, input int n);
    check({tag, "_count"}, rx_q.size(), n);
    for (int i = 0; i < n && i < rx_q.size(); i++)
      check(tag, {16'h0, rx_q[i]}, {16'h0, DW'(base + DW'(i))});
  endtask

  initial begin
    rst = 1'b1; cyc = '0; stb = '0; we = '1; adr = '0; dat = '0; sel = '1;
    ack = 1'b0; err = 1'b0; rty = 1'b0; stall = 1'b0;
    adr[5:4] = 2'b01;
    sel[5:4] = 2'b01;
    step(); step(); settle();
    check("rst_cyc", src_cyc, 0);
    check("rst_grant", grant, 0);
    check("rst_busy", busy, 0);
    check("rst_stall", stall_o, 4'hF);
    check("rst_ack", ack_o, 0);
    rst = 1'b0;

    // Port 0: 10-word frame, ack one cycle after each word.
    rx_q.delete();
    cyc[0] = 1'b1; stb[0] = 1'b1; set_dat(0, 16'h1000); settle();
    check("t1_idle_grant", grant, 0);
    check("t1_idle_stall", stall_o, 4'hF);
    step();
    for (int i = 0; i < 10; i++) begin
      set_dat(0, DW'(16'h1000 + i));
      ack = (i > 0);
      settle();
      check("t1_stb", src_stb, 1);
      check("t1_dat", src_dat, 32'h1000 + i);
      if (i == 0) begin
        check("t1_grant", grant, 4'b0001);
        check("t1_src_cyc", src_cyc, 1);
        check("t1_we", src_we, 1);
      end
      if (i == 1) check("t1_ack_route", ack_o, 4'b0001);
      step();
    end
    cyc[0] = 1'b0; stb[0] = 1'b0; ack = 1'b1; settle();
    check("t1_drop_cyc", src_cyc, 1);
    check("t1_last_ack", ack_o, 4'b0001);
    step();
    ack = 1'b0; settle();
    check("t1_end_cyc", src_cyc, 0);
    check("t1_end_busy", busy, 0);
    check_rx("t1_rx", 16'h1000, 10);
    $display("txn: port 0 frame, %0d words", rx_q.size());

    // Ports 1 and 3 request together, then re-request: expect 1,3,1,3.
    cyc[1] = 1'b1; stb[1] = 1'b1; set_dat(1, 16'h1111);
    cyc[3] = 1'b1; stb[3] = 1'b1; set_dat(3, 16'h3333);
    settle();
    for (int f = 0; f < 4; f++) begin
      int g;
      g = order[f];
      step(); settle();
      check("t2_grant", grant, 1 << g);
      check("t2_dat", src_dat, (g == 1) ? 32'h1111 : 32'h3333);
      check("t2_stall", stall_o, 4'hF ^ (1 << g));
      step();
      cyc[g] = 1'b0; stb[g] = 1'b0; ack = 1'b1; settle();
      check("t2_ack", ack_o, 1 << g);
      step();
      ack = 1'b0;
      if (f < 2) begin
        cyc[g] = 1'b1; stb[g] = 1'b1;
      end
      settle();
      check("t2_gap", src_cyc, 0);
      $display("txn: frame %0d granted to port %0d", f, g);
    end

    // Port 2: ack withheld, outstanding limit, then drain with 3 acks pending.
    rx_q.delete();
    cyc[2] = 1'b1; stb[2] = 1'b1; set_dat(2, 16'h2000);
    step();
    for (int i = 0; i < 4; i++) begin
      set_dat(2, DW'(16'h2000 + i)); settle();
      check("t3_stb", src_stb, 1);
      check("t3_stall", stall_o, 4'hB);
      if (i == 0) begin
        check("t3_adr", src_adr, 2'b01);
        check("t3_sel", src_sel, 2'b01);
      end
      step();
    end
    set_dat(2, 16'h2004); settle();
    check("t3_full_stb", src_stb, 0);
    check("t3_full_stall", stall_o, 4'hF);
    step(); settle();
    check("t3_full_stb2", src_stb, 0);
    ack = 1'b1; settle();
    check("t3_ack_cycle_stb", src_stb, 0);
    check("t3_ack_route", ack_o, 4'b0100);
    step(); settle();
    check("t3_resume_stb", src_stb, 1);
    check("t3_resume_dat", src_dat, 32'h2004);
    step();
    set_dat(2, 16'h2005); settle();
    check("t3_resume_stb2", src_stb, 1);
    step();
    cyc[2] = 1'b0; stb[2] = 1'b0; ack = 1'b0;
    cyc[0] = 1'b1; stb[0] = 1'b1; set_dat(0, 16'h5000); settle();
    check("t3_drop_cyc", src_cyc, 1);
    step();
    for (int k = 0; k < 3; k++) begin
      ack = 1'b1; settle();
      check("t3_drain_cyc", src_cyc, 1);
      check("t3_drain_stb", src_stb, 0);
      check("t3_drain_grant", grant, 4'b0100);
      check("t3_drain_ack", ack_o, 4'b0100);
      step();
    end
    ack = 1'b0; settle();
    check("t3_idle_cyc", src_cyc, 0);
    check_rx("t3_rx", 16'h2000, 6);
    $display("txn: port 2 frame, %0d words, drained", rx_q.size());

    // Port 0 granted next; downstream stall held 5 cycles mid-frame.
    step();
    rx_q.delete(); settle();
    check("t5_grant", grant, 4'b0001);
    step();
    set_dat(0, 16'h5001); ack = 1'b1;
    step();
    set_dat(0, 16'h5002); stall = 1'b1;
    for (int k = 0; k < 5; k++) begin
      ack = (k == 0); settle();
      check("t5_stall", stall_o, 4'hF);
      check("t5_stb_held", src_stb, 1);
      step();
    end
    stall = 1'b0; ack = 1'b0; settle();
    check("t5_release", stall_o, 4'hE);
    step();
    set_dat(0, 16'h5003); ack = 1'b1;
    step();
    cyc[0] = 1'b0; stb[0] = 1'b0; ack = 1'b1;
    step();
    ack = 1'b0; settle();
    check("t5_end_cyc", src_cyc, 0);
    check_rx("t5_rx", 16'h5000, 4);
    $display("txn: port 0 frame, %0d words with stall", rx_q.size());

    // Reset mid-frame, then port 0 regains first priority.
    cyc[1] = 1'b1; stb[1] = 1'b1; set_dat(1, 16'h6000);
    step(); settle();
    check("t6_grant", grant, 4'b0010);
    step();
    rst = 1'b1; ack = 1'b1;
    step(); settle();
    check("t6_rst_cyc", src_cyc, 0);
    check("t6_rst_grant", grant, 0);
    check("t6_rst_stall", stall_o, 4'hF);
    check("t6_rst_ack", ack_o, 0);
    check("t6_rst_stb", src_stb, 0);
    rst = 1'b0; ack = 1'b0; cyc[0] = 1'b1;
    step(); settle();
    check("t6_rr_reset", grant, 4'b0001);
    cyc = '0; stb = '0;
    step(); settle();
    check("t6_idle", busy, 0);
    $display("txn: reset abort on port 1");

`ifdef WRF_ARB_TIMEOUT_EN
    // Port 2 idles in grant until the watchdog aborts; port 3 waits.
    cyc[2] = 1'b1; cyc[3] = 1'b1;
    step();
    for (int k = 0; k < 15; k++) begin
      settle();
      check("t7_no_err", err_o, 0);
      step();
    end
    settle();
    check("t7_err", err_o, 4'b0100);
    check("t7_err_cyc", src_cyc, 1);
    step(); settle();
    check("t7_abort_cyc", src_cyc, 0);
    check("t7_abort_grant", grant, 0);
    check("t7_err_pulse", err_o, 0);
    cyc[2] = 1'b0;
    step(); settle();
    check("t7_next", grant, 4'b1000);
    cyc[3] = 1'b0;
    step(); settle();
    check("t7_idle", busy, 0);
    $display("txn: watchdog abort on port 2");
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
